mem_arbiter: RTL
================

# mem_arbiter

Shares the single-read-port/single-write-port word memory (32K x 16, word address [15:1], two-cycle read latency) between NREQ requesters, typically the parallel cores' fetch/load and store units. Read and write ports are arbitrated independently, each round-robin. The block tracks in-flight reads through the memory's two-stage read pipeline and routes each returned word to the requester that issued it. It sits directly between the requesters and the memory instance.

## Interface
- NREQ, 4: number of requesters, 2..8
- clk  in  1  clock; memory is clocked on the same edge
- rst_n  in  1  asynchronous, active-low reset
- rd_req_valid  in  NREQ  per-requester read request
- rd_req_addr  in  NREQ*15  packed word addresses; requester i at [15*i+14:15*i]
- rd_req_ready  out  NREQ  one-hot grant; the request is accepted in the cycle valid & ready
- rd_rsp_valid  out  NREQ  one-hot; read data for requester i is valid this cycle
- rd_rsp_data  out  16  shared read data bus, meaningful only when a rd_rsp_valid bit is set
- wr_req_valid  in  NREQ  per-requester write request
- wr_req_addr  in  NREQ*15  packed word addresses
- wr_req_data  in  NREQ*16  packed write data
- wr_req_ready  out  NREQ  one-hot write grant
- mem_raddr  out  15  to memory read address input
- mem_rdata  in  16  from memory read data output
- mem_wen  out  1  to memory write enable
- mem_waddr  out  15  to memory write address
- mem_wdata  out  16  to memory write data

## Operation
- Requesters hold valid, addr and data stable until ready; no withdrawal once valid is asserted.
- Read arbiter:
  - Combinational grant each cycle among set rd_req_valid bits.
  - Priority starts at (rd_last+1) mod NREQ.
  - mem_raddr = granted address; 0 when there is no grant.
  - rd_last updates to the granted index on the clock edge of a grant.
- Read tracking:
  - 2-stage shift register of {valid, one-hot grant}.
  - Stage 2 drives rd_rsp_valid; rd_rsp_data = mem_rdata, passed through combinationally.
  - Throughput: one read per cycle.
- Write arbiter:
  - Identical policy with its own pointer wr_last.
  - mem_wen = any write grant; mem_waddr/mem_wdata mux from the granted requester, 0 when idle.
- Independence: a read and a write may both be granted in the same cycle, to the same or different requesters.
- Same-address read/write in the same cycle: the read returns the NEW data (the write commits at the edge that registers the read address). This is required behaviour, not a hazard.
- Pointers: reset to NREQ-1, so requester 0 has first priority.
- A single requester with valid held high is granted every cycle.

## Timing
- Read issued (granted) in cycle c produces rd_rsp_valid[i] in cycle c+2, with the data word.
- Write granted in cycle c is committed at the end of cycle c.
- Grant/ready are combinational from valid and the pointers; no combinational path from mem_rdata to any ready.
- Reset (async assert, any time):
  - Pipeline valids and rd_rsp_valid clear immediately; in-flight reads are dropped, no response.
  - Pointers return to NREQ-1.
  - All readies are 0 while rst_n is low.
  - mem_wen is 0 while rst_n is low; mem_raddr and mem_waddr are 0.
- Deassertion: first grant possible in the first cycle after rst_n is sampled high.
- Starvation bound: with all NREQ requesting continuously, each requester is granted once every NREQ cycles.

## Structure
- Shared header mem_defs.vh holds ADDR_W=15, DATA_W=16, RD_LATENCY=2. The memory model and this block both use it.
- Sub-module rr_arbiter:
  - Parameter N; inputs clk, rst_n, req[N]; outputs grant[N] (one-hot) and gidx.
  - Owns its last-grant pointer.
  - Instantiated twice, once for reads and once for writes.
- mem_arbiter itself holds the address/data muxes and the 2-stage read tag pipeline.

## Test plan
- Single read: requester 2 reads addr 0x0010 (preloaded 0xBEEF) in cycle 5 -> rd_req_ready[2]=1 in cycle 5; rd_rsp_valid=4'b0100 and rd_rsp_data=0xBEEF in cycle 7.
- Round-robin fairness: all 4 requesters hold reads from reset -> grants 0,1,2,3,0,… in consecutive cycles. Each response arrives 2 cycles after its grant, with the correct per-address data.
- Write then read-back: requester 1 writes 0x1234 to 0x0020 while requester 3 reads 0x0020 in the same cycle -> requester 3 receives 0x1234 two cycles later.
- Concurrent ports: requester 0 reads and requester 0 writes in the same cycle -> both ready bits are 1. The write lands, and the read response arrives in c+2.
- Mid-flight reset: rst_n pulled low one cycle after a read grant -> no rd_rsp_valid ever appears for it. After release, requester 0 wins the first grant.
- Hold-valid streaming: requester 3 alone issues 8 back-to-back reads of 0x0000..0x0007 -> 8 consecutive responses in order, first one 2 cycles after the first grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths and types for the memory arbiter and its memory model.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned RD_LATENCY = 2;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled.
// The slave view belongs to the arbiter; the master view to the requesters and memory.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 4
);

   logic [NREQ-1:0]        rd_req_valid;
   logic [NREQ*ADDR_W-1:0] rd_req_addr;
   logic [NREQ-1:0]        rd_req_ready;
   logic [NREQ-1:0]        rd_rsp_valid;
   data_t                  rd_rsp_data;

   logic [NREQ-1:0]        wr_req_valid;
   logic [NREQ*ADDR_W-1:0] wr_req_addr;
   logic [NREQ*DATA_W-1:0] wr_req_data;
   logic [NREQ-1:0]        wr_req_ready;

   addr_t                  mem_raddr;
   data_t                  mem_rdata;
   logic                   mem_wen;
   addr_t                  mem_waddr;
   data_t                  mem_wdata;

   modport slave (
      input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, mem_rdata,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
      output mem_raddr, mem_wen, mem_waddr, mem_wdata
   );

   modport master (
      output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, mem_rdata,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
      input  mem_raddr, mem_wen, mem_waddr, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, priority starting one past
// the last granted index. Grants are forced low while reset is asserted.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] gidx
);

   localparam int unsigned IdxW = $clog2(N);

   logic [IdxW-1:0] last_q, last_d;
   logic [IdxW-1:0] cand;
   logic            found;

   // Scan requesters from last+1 around the ring; first set request wins.
   always_comb begin
      grant = '0;
      gidx  = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = IdxW'((32'(last_q) + k) % N);
         if (!found && rst_n && req[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            found       = 1'b1;
         end
      end
   end

   // Pointer follows the winner; holds when nothing is granted.
   always_comb begin
      last_d = last_q;
      if (found) begin
         last_d = gidx;
      end
   end

   // Pointer resets to N-1 so requester 0 has first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= IdxW'(N - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a 1R1W word memory between NREQ requesters. Read and write ports are
// arbitrated independently; a tag pipeline matching the memory read latency
// steers each returned word back to the requester that issued it.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_arbiter_if.slave   bus
);

   localparam int unsigned IdxW = $clog2(NREQ);

   logic [NREQ-1:0] rd_grant, wr_grant;
   logic [IdxW-1:0] rd_gidx, wr_gidx;

   addr_t rd_addr [NREQ];
   addr_t wr_addr [NREQ];
   data_t wr_data [NREQ];

   // A non-zero tag in a stage doubles as that stage's valid bit.
   logic [RD_LATENCY-1:0][NREQ-1:0] tag_q, tag_d;

   // Unpack the flat request buses into per-requester words.
   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         rd_addr[i] = bus.rd_req_addr[i*ADDR_W +: ADDR_W];
         wr_addr[i] = bus.wr_req_addr[i*ADDR_W +: ADDR_W];
         wr_data[i] = bus.wr_req_data[i*DATA_W +: DATA_W];
      end
   end

   rr_arbiter #(
      .N (NREQ)
   ) u_rd_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bus.rd_req_valid),
      .grant (rd_grant),
      .gidx  (rd_gidx)
   );

   rr_arbiter #(
      .N (NREQ)
   ) u_wr_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bus.wr_req_valid),
      .grant (wr_grant),
      .gidx  (wr_gidx)
   );

   assign bus.rd_req_ready = rd_grant;
   assign bus.wr_req_ready = wr_grant;

   // Memory-side muxes; everything parks at zero when the port is idle.
   always_comb begin
      bus.mem_raddr = '0;
      bus.mem_wen   = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      if (|rd_grant) begin
         bus.mem_raddr = rd_addr[rd_gidx];
      end
      if (|wr_grant) begin
         bus.mem_wen   = 1'b1;
         bus.mem_waddr = wr_addr[wr_gidx];
         bus.mem_wdata = wr_data[wr_gidx];
      end
   end

   // Shift the one-hot read grant along with the memory's read pipeline.
   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = rd_grant;
      for (int s = 1; s < int'(RD_LATENCY); s++) begin
         tag_d[s] = tag_q[s-1];
      end
   end

   // Async reset drops in-flight reads so no stale response escapes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign bus.rd_rsp_valid = tag_q[RD_LATENCY-1];
   assign bus.rd_rsp_data  = bus.mem_rdata;

endmodule
